occupancy_counter: RTL and testbench
====================================

# occupancy_counter

Upstream stage of the room-rule checker. Takes raw entry/exit sensor inputs for three rooms, debounces each of the six inputs, and converts each debounced rising edge into a one-cycle event. It maintains a saturating 3-bit occupancy count per room, presented as C1/C2/C3 to the rule checker.

## Interface
- DEBOUNCE_CYCLES, default 1_000_000: cycles a synchronised input must hold a new level before it is accepted (N). Legal N ≥ 2. The bench uses 4.
- MAX_COUNT, default 7: saturation ceiling per room. Legal range 1..7.
- clock  in  1  single system clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enter_raw  in  3  raw entry sensors; bit i = room i+1, asynchronous to clock.
- exit_raw  in  3  raw exit sensors; bit i = room i+1, asynchronous to clock.
- C1, C2, C3  out  3 each  registered occupancy of rooms 1..3.
- full  out  3  bit i high while room i+1 count == MAX_COUNT (decoded from registers, glitch-free).
- reject  out  3  one-cycle pulse when a room event is discarded (enter at MAX_COUNT, or exit at 0).

## Operation
- Reset values:
  - C1 = C2 = C3 = 0.
  - full = 0, reject = 0.
  - All synchroniser flops, debounce counters, stable levels and pulses = 0.
- Per input, the debounce chain is:
  - 2-flop synchroniser, giving s.
  - Stable level register st.
  - Counter dc of width $clog2(N).
- Debounce rule, each cycle:
  - If s == st: dc ← 0.
  - Else if dc == N-1: st ← s and dc ← 0.
  - Else: dc ← dc+1.
- Any excursion shorter than N cycles leaves st unchanged. The counter restarts from 0 on every bounce.
- Event pulse p: registered, set in the same cycle st goes 0→1, high exactly one cycle. Falling edges of st produce nothing.
- Per-room update on the edge after the pulses (ent, ext):
  - ent & ext both high: count unchanged, reject = 0 (simultaneous events cancel).
  - ent only:
    - count < MAX_COUNT: count+1.
    - Otherwise: count unchanged, reject pulse.
  - ext only:
    - count > 0: count−1.
    - Otherwise: count unchanged, reject pulse.
  - Neither: hold.
- Rooms are fully independent. Events in different rooms in the same cycle all apply.
- Counts never wrap. Arithmetic is 3-bit unsigned with explicit bounds checks before add/subtract.
- A sensor held high indefinitely generates exactly one event. It must return low and then rise again to count again.
- Reset asserted mid-debounce or mid-pulse discards the pending event. After release, an input already high must be debounced afresh and yields one event.

## Timing
- Raw input rising and stable from before clock edge E0:
  - s high after E1.
  - st and p high after E(N+1).
  - Count and full updated at E(N+2).
  - Total latency is N+2 edges.
- reject pulses in the same cycle the count would have changed (after E(N+2)), for one cycle.
- full and reject are registered or decoded only from registered state; no path from raw inputs to outputs.
- Maximum sustained event rate per input: one per 2N+4 cycles (high-debounce plus low-debounce).
- Reset deassertion is assumed synchronised externally. Outputs remain 0 until the first event completes.

## Structure
- Shared package:
  - NUM_ROOMS = 3.
  - Count width CNT_W = 3.
  - Helper function for the debounce counter width from N.
- One sub-module: debounce_pulse (params N; ports clock, reset, raw, pulse, level). Instantiated six times (3 enter, 3 exit).
- Top level holds three occupancy registers, saturation logic, and full/reject decode. No further hierarchy.

## Test plan
- Reset check: assert reset mid-run with counts nonzero → C1..C3, full and reject read 0 asynchronously, before the next clock edge.
- Single entry: N=4; enter_raw[0] rises before E0 and is held 10 cycles → C1 goes 0→1 exactly at E6; C2 and C3 unchanged; reject stays 0.
- Glitch rejection: N=4; exit_raw[1] toggles every 2 cycles for 20 cycles, then held high → no event during toggling; exactly one decrement N+2 edges after the final rise (starting C2 = 3 → 2).
- Saturation and underflow: drive 8 separate entries into room 3 → C3 = 7, full[2] = 1, one reject[2] pulse on the 8th. Then 8 exits → C3 = 0, one reject[2] pulse on the 8th, full[2] = 0 after the first exit.
- Simultaneous and cross-room: with C1 = 2, assert enter_raw[0] and exit_raw[0] together, plus enter_raw[1] → C1 stays 2, no reject, C2 increments on the same edge.
- Reset mid-debounce: enter_raw[2] high; reset pulsed at cycle N−1, input kept high → C3 still 0 at the original completion edge; increments to 1 exactly N+2 edges after reset release.

Source files
------------

// File: rtl/occupancy_counter_pkg.sv
// occupancy_counter_pkg
//   Shared constants, types and helpers for the occupancy counter slice.
//   NUM_ROOMS   : number of rooms tracked (one enter + one exit sensor each)
//   CNT_W       : width of a per-room occupancy count
//   count_t     : per-room occupancy count type
//   room_act_e  : per-room update decision for one cycle
//   dc_width()  : debounce counter width for a hold time of n cycles
package occupancy_counter_pkg;

    localparam int unsigned NUM_ROOMS = 3;
    localparam int unsigned CNT_W     = 3;

    typedef logic [CNT_W-1:0] count_t;

    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_INC    = 2'd1,
        ACT_DEC    = 2'd2,
        ACT_REJECT = 2'd3
    } room_act_e;

    // Counter must hold values 0..n-1; never narrower than one bit.
    function automatic int unsigned dc_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/occupancy_counter_if.sv
// occupancy_counter_if
//   Bundles the sensor inputs and occupancy outputs of occupancy_counter.
//   enter_raw : raw entry sensors, bit i = room i+1 (asynchronous)
//   exit_raw  : raw exit sensors,  bit i = room i+1 (asynchronous)
//   C1..C3    : registered occupancy of rooms 1..3
//   full      : bit i high while room i+1 is at its ceiling
//   reject    : one-cycle pulse when a room event is discarded
//   master    : sensor side / rule-checker side (drives raw, reads counts)
//   slave     : the counter itself
interface occupancy_counter_if;
    import occupancy_counter_pkg::*;

    logic [NUM_ROOMS-1:0] enter_raw;
    logic [NUM_ROOMS-1:0] exit_raw;
    count_t               C1;
    count_t               C2;
    count_t               C3;
    logic [NUM_ROOMS-1:0] full;
    logic [NUM_ROOMS-1:0] reject;

    modport master (
        output enter_raw, exit_raw,
        input  C1, C2, C3, full, reject
    );

    modport slave (
        input  enter_raw, exit_raw,
        output C1, C2, C3, full, reject
    );

endinterface

// File: rtl/occupancy_counter_debounce_pulse.sv
// debounce_pulse
//   Synchronises one raw sensor, debounces it and emits a one-cycle pulse
//   on each accepted rising edge.
//   N      : cycles the synchronised input must hold a new level (N >= 2)
//   clock  : system clock
//   reset  : asynchronous active-high reset
//   raw    : asynchronous sensor input
//   pulse  : one-cycle pulse, registered, set as level goes 0->1
//   level  : debounced stable level
module debounce_pulse
    import occupancy_counter_pkg::*;
#(
    parameter int unsigned N = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse,
    output logic level
);

    localparam int unsigned     DC_W = dc_width(N);
    localparam logic [DC_W-1:0] LAST = DC_W'(N - 1);

    logic            meta;
    logic            s;
    logic            st;
    logic [DC_W-1:0] dc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta  <= 1'b0;
            s     <= 1'b0;
            st    <= 1'b0;
            dc    <= '0;
            pulse <= 1'b0;
        end else begin
            meta  <= raw;
            s     <= meta;
            pulse <= 1'b0;
            if (s == st) begin
                // Any bounce back to the stable level restarts the hold time.
                dc <= '0;
            end else if (dc == LAST) begin
                st    <= s;
                dc    <= '0;
                pulse <= s;
            end else begin
                dc <= dc + 1'b1;
            end
        end
    end

    assign level = st;

endmodule

// File: rtl/occupancy_counter.sv
// occupancy_counter
//   Debounces entry/exit sensors for three rooms and keeps a saturating
//   occupancy count per room.
//   DEBOUNCE_CYCLES : hold time for a sensor level change (>= 2)
//   MAX_COUNT       : per-room saturation ceiling (1..7)
//   clock           : system clock
//   reset           : asynchronous active-high reset
//   bus             : slave side of occupancy_counter_if
//                     (enter_raw, exit_raw in; C1..C3, full, reject out)
module occupancy_counter
    import occupancy_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned MAX_COUNT       = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    occupancy_counter_if.slave   bus
);

    localparam count_t MAX_C = CNT_W'(MAX_COUNT);

    logic [NUM_ROOMS-1:0]   ent;
    logic [NUM_ROOMS-1:0]   ext;
    logic [2*NUM_ROOMS-1:0] unused_level;
    count_t                 cnt [NUM_ROOMS];
    room_act_e              act [NUM_ROOMS];
    logic [NUM_ROOMS-1:0]   reject_q;

    for (genvar g = 0; g < NUM_ROOMS; g++) begin : g_room
        debounce_pulse #(.N(DEBOUNCE_CYCLES)) u_enter (
            .clock (clock),
            .reset (reset),
            .raw   (bus.enter_raw[g]),
            .pulse (ent[g]),
            .level (unused_level[2*g])
        );
        debounce_pulse #(.N(DEBOUNCE_CYCLES)) u_exit (
            .clock (clock),
            .reset (reset),
            .raw   (bus.exit_raw[g]),
            .pulse (ext[g]),
            .level (unused_level[2*g+1])
        );
    end

    // Bounds are checked before any add/subtract so counts never wrap;
    // simultaneous enter and exit cancel without a reject.
    always_comb begin
        for (int unsigned r = 0; r < NUM_ROOMS; r++) begin
            act[r] = ACT_HOLD;
            unique case ({ent[r], ext[r]})
                2'b10:   act[r] = (cnt[r] < MAX_C) ? ACT_INC : ACT_REJECT;
                2'b01:   act[r] = (cnt[r] != '0)   ? ACT_DEC : ACT_REJECT;
                default: act[r] = ACT_HOLD;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NUM_ROOMS; r++) begin
                cnt[r] <= '0;
            end
            reject_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_ROOMS; r++) begin
                reject_q[r] <= 1'b0;
                unique case (act[r])
                    ACT_INC:    cnt[r]      <= cnt[r] + 1'b1;
                    ACT_DEC:    cnt[r]      <= cnt[r] - 1'b1;
                    ACT_REJECT: reject_q[r] <= 1'b1;
                    default:    cnt[r]      <= cnt[r];
                endcase
            end
        end
    end

    always_comb begin
        bus.full = '0;
        for (int unsigned r = 0; r < NUM_ROOMS; r++) begin
            bus.full[r] = (cnt[r] == MAX_C);
        end
    end

    assign bus.C1     = cnt[0];
    assign bus.C2     = cnt[1];
    assign bus.C3     = cnt[2];
    assign bus.reject = reject_q;

endmodule

// File: tb/tb_occupancy_counter.sv
// tb_occupancy_counter
//   Directed bench for occupancy_counter with DEBOUNCE_CYCLES = 4 and
//   MAX_COUNT = 7. A raw input changed just after a sampling point counts
//   the next rising edge as E0; the count updates on E6 (the 7th edge).
module tb_occupancy_counter;
    import occupancy_counter_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned LAT = N + 3;   // edges from change to count update, E0 included

    logic clock;
    logic reset;

    occupancy_counter_if bus ();

    occupancy_counter #(
        .DEBOUNCE_CYCLES (N),
        .MAX_COUNT       (7)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full sensor event: rise, hold past the update, fall, settle low.
    task automatic send(input bit is_exit, input int room, output int rej);
        rej = 0;
        if (is_exit) bus.exit_raw[room] = 1'b1;
        else         bus.enter_raw[room] = 1'b1;
        repeat (LAT) begin
            tick();
            rej += int'(bus.reject[room]);
        end
        if (is_exit) bus.exit_raw[room] = 1'b0;
        else         bus.enter_raw[room] = 1'b0;
        repeat (LAT) begin
            tick();
            rej += int'(bus.reject[room]);
        end
    endtask

    initial begin
        int rej;
        int rej_sum;

        bus.enter_raw = '0;
        bus.exit_raw  = '0;
        reset         = 1'b1;
        repeat (3) tick();
        check("rst_C1", int'(bus.C1), 0);
        check("rst_C2", int'(bus.C2), 0);
        check("rst_C3", int'(bus.C3), 0);
        check("rst_full", int'(bus.full), 0);
        check("rst_reject", int'(bus.reject), 0);
        reset = 1'b0;
        repeat (2) tick();

        // Single entry into room 1: count changes exactly at E6.
        bus.enter_raw[0] = 1'b1;
        rej_sum = 0;
        repeat (LAT - 1) begin
            tick();
            rej_sum += int'(bus.reject);
        end
        check("single_C1_before", int'(bus.C1), 0);
        tick();
        rej_sum += int'(bus.reject);
        check("single_C1_at_E6", int'(bus.C1), 1);
        check("single_C2", int'(bus.C2), 0);
        check("single_C3", int'(bus.C3), 0);
        repeat (3) begin
            tick();
            rej_sum += int'(bus.reject);
        end
        check("single_held_C1", int'(bus.C1), 1);
        check("single_reject", rej_sum, 0);
        bus.enter_raw[0] = 1'b0;
        repeat (LAT) tick();

        // Room 2 up to 3, then a bouncing exit sensor.
        repeat (3) send(1'b0, 1, rej);
        check("glitch_C2_start", int'(bus.C2), 3);
        rej_sum = 0;
        repeat (5) begin
            bus.exit_raw[1] = 1'b1;
            repeat (2) begin tick(); rej_sum += int'(bus.C2 != 3'd3); end
            bus.exit_raw[1] = 1'b0;
            repeat (2) begin tick(); rej_sum += int'(bus.C2 != 3'd3); end
        end
        check("glitch_no_event", rej_sum, 0);
        bus.exit_raw[1] = 1'b1;
        repeat (LAT - 1) tick();
        check("glitch_C2_before", int'(bus.C2), 3);
        tick();
        check("glitch_C2_after", int'(bus.C2), 2);
        repeat (LAT) tick();
        check("glitch_held_C2", int'(bus.C2), 2);
        bus.exit_raw[1] = 1'b0;
        repeat (LAT) tick();

        // Room 3 saturation.
        rej_sum = 0;
        repeat (7) begin
            send(1'b0, 2, rej);
            rej_sum += rej;
        end
        check("sat_C3", int'(bus.C3), 7);
        check("sat_full", int'(bus.full), 3'b100);
        check("sat_no_reject", rej_sum, 0);
        send(1'b0, 2, rej);
        check("sat_8th_reject", rej, 1);
        check("sat_8th_C3", int'(bus.C3), 7);

        // Room 3 underflow.
        send(1'b1, 2, rej);
        check("under_first_C3", int'(bus.C3), 6);
        check("under_first_full", int'(bus.full), 0);
        check("under_first_reject", rej, 0);
        rej_sum = 0;
        repeat (6) begin
            send(1'b1, 2, rej);
            rej_sum += rej;
        end
        check("under_C3_zero", int'(bus.C3), 0);
        check("under_no_reject", rej_sum, 0);
        send(1'b1, 2, rej);
        check("under_8th_reject", rej, 1);
        check("under_8th_C3", int'(bus.C3), 0);

        // Simultaneous enter/exit in room 1 plus entry in room 2.
        send(1'b0, 0, rej);
        check("simul_C1_start", int'(bus.C1), 2);
        bus.enter_raw[0] = 1'b1;
        bus.exit_raw[0]  = 1'b1;
        bus.enter_raw[1] = 1'b1;
        rej_sum = 0;
        repeat (LAT - 1) begin
            tick();
            rej_sum += int'(bus.reject);
        end
        check("simul_C2_before", int'(bus.C2), 2);
        tick();
        rej_sum += int'(bus.reject);
        check("simul_C1", int'(bus.C1), 2);
        check("simul_C2", int'(bus.C2), 3);
        tick();
        rej_sum += int'(bus.reject);
        check("simul_reject", rej_sum, 0);
        bus.enter_raw = '0;
        bus.exit_raw  = '0;
        repeat (LAT) tick();

        // Asynchronous reset mid-run, observed before the next clock edge.
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_C1", int'(bus.C1), 0);
        check("async_rst_C2", int'(bus.C2), 0);
        check("async_rst_C3", int'(bus.C3), 0);
        check("async_rst_full", int'(bus.full), 0);
        check("async_rst_reject", int'(bus.reject), 0);
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Reset during debounce discards the pending event.
        bus.enter_raw[2] = 1'b1;
        repeat (N - 1) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (LAT - 1) tick();
        check("rst_deb_C3_before", int'(bus.C3), 0);
        tick();
        check("rst_deb_C3_after", int'(bus.C3), 1);
        repeat (LAT) tick();
        check("rst_deb_C3_held", int'(bus.C3), 1);
        check("rst_deb_C1", int'(bus.C1), 0);
        bus.enter_raw[2] = 1'b0;
        repeat (LAT) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
